// File: rtl/mem_bus_responder_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_bus_responder_if : controller <-> responder data-memory bus        |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface mem_bus_responder_if;
  logic [9:0] ADDR;
  logic [9:0] DOUT;
  logic       W_D;
  logic       rd_req;
  logic [9:0] DIN;
  logic       ready;

  modport master (output ADDR, DOUT, W_D, rd_req, input  DIN, ready);
  modport slave  (input  ADDR, DOUT, W_D, rd_req, output DIN, ready);
endinterface
`default_nettype wire

// File: rtl/mem_bus_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_bus_responder : 128-word RAM, LED register and synchronised SW     |
// | behind a wait-stated request/ready bus.                     Rev 1.0    |
// +-----------------------------------------------------------------------+
module mem_bus_responder #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  mem_bus_responder_if.slave       bus,
  input  logic [9:0]               SW,
  output logic [9:0]               LEDR,
  output logic                     bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [9:0]  addr_q;
  logic [9:0]  data_q;
  logic        wr_q;
  logic        ready_q;
  logic [9:0]  din_q;
  logic [9:0]  ledr_q;
  logic        err_q;
  logic [9:0]  sw_meta_q;
  logic [9:0]  sw_sync_q;
  logic [9:0]  ram [128];
  logic [2:0]  region;

  assign region    = addr_q[9:7];
  assign bus.DIN   = din_q;
  assign bus.ready = ready_q;
  assign LEDR      = ledr_q;
  assign bus_err   = err_q;

  // RAM has no reset; a reset in the commit cycle suppresses the write.
  always_ff @(posedge clock) begin
    if (!reset && state_q == S_RESP && wr_q && region == 3'd0) begin
      ram[addr_q[6:0]] <= data_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 10'd0;
      data_q    <= 10'd0;
      wr_q      <= 1'b0;
      ready_q   <= 1'b0;
      din_q     <= 10'd0;
      ledr_q    <= 10'd0;
      err_q     <= 1'b0;
      sw_meta_q <= 10'd0;
      sw_sync_q <= 10'd0;
    end else begin
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
      ready_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.W_D || bus.rd_req) begin
            addr_q <= bus.ADDR;
            data_q <= bus.DOUT;
            wr_q   <= bus.W_D;
            if (WAIT_STATES > 0) begin
              state_q <= S_WAIT;
              cnt_q   <= c_WAIT_LOAD;
            end else begin
              state_q <= S_RESP;
              ready_q <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          // Writes to SW are dropped silently; only unmapped regions flag an error.
          if (wr_q) begin
            if (region == 3'd1) ledr_q <= data_q;
            if (region >= 3'd3) err_q  <= 1'b1;
          end else begin
            case (region)
              3'd0:    din_q <= ram[addr_q[6:0]];
              3'd1:    din_q <= ledr_q;
              3'd2:    din_q <= sw_sync_q;
              default: begin
                din_q <= 10'd0;
                err_q <= 1'b1;
              end
            endcase
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mem_bus_responder : directed + randomized bench with memory model   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mem_bus_responder;
  localparam int WS = 1;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] SW;
  logic [9:0] LEDR;
  logic       bus_err;

  mem_bus_responder_if bus ();

  mem_bus_responder #(.WAIT_STATES(WS)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .SW      (SW),
    .LEDR    (LEDR),
    .bus_err (bus_err)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  logic [9:0] ram_m [128];
  logic [9:0] led_m;
  logic [9:0] din_m;
  logic [9:0] sw_m;
  logic       err_m;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one completed access, straight from the address map.
  task automatic model(input logic wr, input logic [9:0] a, input logic [9:0] d);
    case (a[9:7])
      3'd0: if (wr) ram_m[a[6:0]] = d; else din_m = ram_m[a[6:0]];
      3'd1: if (wr) led_m = d; else din_m = led_m;
      3'd2: if (!wr) din_m = sw_m;
      default: begin
        err_m = 1'b1;
        if (!wr) din_m = 10'd0;
      end
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_din"},  bus.DIN, din_m);
    check({tag, "_ledr"}, LEDR, led_m);
    check({tag, "_err"},  {9'd0, bus_err}, {9'd0, err_m});
  endtask

  task automatic txn(input logic wr, input logic rd, input logic [9:0] a, input logic [9:0] d);
    @(negedge clock);
    bus.ADDR = a; bus.DOUT = d; bus.W_D = wr; bus.rd_req = rd;
    @(posedge clock);
    #1;
    bus.W_D = 1'b0; bus.rd_req = 1'b0;
    bus.ADDR = 10'($urandom); bus.DOUT = 10'($urandom);
    for (int j = 0; j <= WS; j++) begin
      @(negedge clock);
      check("ready_pulse", {9'd0, bus.ready}, (j == WS) ? 10'd1 : 10'd0);
    end
    model(wr, a, d);
    @(negedge clock);
    check("ready_end", {9'd0, bus.ready}, 10'd0);
    check_outputs("txn");
  endtask

  task automatic set_sw(input logic [9:0] v);
    @(negedge clock);
    SW = v; sw_m = v;
    repeat (3) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    led_m = 10'd0; din_m = 10'd0; err_m = 1'b0;
  endtask

  initial begin
    logic [9:0] a;
    logic [9:0] old;
    int         op;
    reset = 1'b1; SW = 10'd0; sw_m = 10'd0;
    bus.ADDR = 10'd0; bus.DOUT = 10'd0; bus.W_D = 1'b0; bus.rd_req = 1'b0;
    led_m = 10'd0; din_m = 10'd0; err_m = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("idle_ready", {9'd0, bus.ready}, 10'd0);
      check_outputs("idle");
    end

    txn(1'b1, 1'b0, 10'h005, 10'h2A5);
    txn(1'b0, 1'b1, 10'h005, 10'h000);
    check("ram_rd_2a5", bus.DIN, 10'h2A5);

    txn(1'b1, 1'b0, 10'h080, 10'h3FF);
    check("led_wr", LEDR, 10'h3FF);
    txn(1'b0, 1'b1, 10'h0FF, 10'h000);
    check("led_rd", bus.DIN, 10'h3FF);
    txn(1'b1, 1'b0, 10'h100, 10'h123);
    check("sw_wr_led", LEDR, 10'h3FF);

    set_sw(10'h155);
    txn(1'b0, 1'b1, 10'h100, 10'h000);
    check("sw_155", bus.DIN, 10'h155);
    set_sw(10'h0AA);
    txn(1'b0, 1'b1, 10'h100, 10'h000);
    check("sw_0aa", bus.DIN, 10'h0AA);

    for (int i = 0; i < 128; i++) txn(1'b1, 1'b0, 10'(i), 10'($urandom));

    for (int i = 0; i < 80; i++) begin
      a  = {3'($urandom_range(0, 2)), 7'($urandom)};
      op = $urandom_range(0, 3);
      if (op == 3) set_sw(10'($urandom));
      else txn(op != 0, op != 1, a, 10'($urandom));
    end

    txn(1'b0, 1'b1, 10'h0C0, 10'h000);
    old = bus.DIN;
    txn(1'b1, 1'b1, 10'h010, 10'h011);
    check("both_din_hold", bus.DIN, old);
    txn(1'b0, 1'b1, 10'h010, 10'h000);
    check("both_ram16", bus.DIN, 10'h011);

    txn(1'b0, 1'b1, 10'h1C3, 10'h000);
    check("unmapped_din", bus.DIN, 10'h000);
    check("unmapped_err", {9'd0, bus_err}, 10'd1);
    txn(1'b1, 1'b0, 10'h005, 10'h1A1);
    txn(1'b0, 1'b1, 10'h005, 10'h000);
    check("err_sticky", {9'd0, bus_err}, 10'd1);

    // Reset during WAIT of a RAM write must abort it.
    old = ram_m[32];
    @(negedge clock);
    bus.ADDR = 10'h020; bus.DOUT = ~old; bus.W_D = 1'b1; bus.rd_req = 1'b0;
    @(posedge clock);
    #1;
    bus.W_D = 1'b0;
    @(negedge clock);
    check("abort_wait_ready", {9'd0, bus.ready}, 10'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    led_m = 10'd0; din_m = 10'd0; err_m = 1'b0;
    sw_m = SW;
    check("abort_ready", {9'd0, bus.ready}, 10'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("abort_no_ready", {9'd0, bus.ready}, 10'd0);
    end
    check_outputs("after_reset");
    txn(1'b0, 1'b1, 10'h020, 10'h000);
    check("abort_ram_kept", bus.DIN, old);

    do_reset();
    @(negedge clock);
    check_outputs("final_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
